// File: rtl/wb_ram_responder.sv
// Wishbone B4 classic-cycle RAM responder: 32-bit word RAM, byte-lane writes, programmable wait states.
// Define RAM_ERR_EN to answer out-of-range addresses with err_o instead of aliasing them.
module wb_ram_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADR_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             err_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [3:0]  WS_L = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [3:0]     cnt_r;
    logic [3:0]     cnt_nx_s;
    logic           accept_s;
    logic           commit_s;

    logic [AW-1:0]  idx_r;
    logic           we_r;
    logic [3:0]     sel_r;
    logic [31:0]    wdat_r;
    logic           oor_r;
    logic           err_r;

    logic           req_oor_s;
    logic [AW-1:0]  cur_idx_s;
    logic           cur_we_s;
    logic [3:0]     cur_sel_s;
    logic [31:0]    cur_dat_s;
    logic           cur_oor_s;

    logic [31:0]    mem_r [DEPTH];

`ifdef RAM_ERR_EN
    assign req_oor_s = |adr_i[ADR_W-1:AW+2];
`else
    assign req_oor_s = 1'b0;
`endif

    // With zero wait states the commit happens on the accepting edge, so the live inputs are used.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_idx_s = adr_i[AW+1:2];
            cur_we_s  = we_i;
            cur_sel_s = sel_i;
            cur_dat_s = dat_i;
            cur_oor_s = req_oor_s;
        end else begin
            cur_idx_s = idx_r;
            cur_we_s  = we_r;
            cur_sel_s = sel_r;
            cur_dat_s = wdat_r;
            cur_oor_s = oor_r;
        end
    end

    // State and wait counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic; commit_s marks the edge that enters RESP.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    accept_s = 1'b1;
                    cnt_nx_s = WS_L;
                    if (WS_L != 4'd0) begin
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_RESP;
                        commit_s   = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end else if (cnt_r == 4'd1) begin
                    state_nx_s = ST_RESP;
                    cnt_nx_s   = 4'd0;
                    commit_s   = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // Request holding registers, loaded only on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r  <= '0;
            we_r   <= 1'b0;
            sel_r  <= 4'd0;
            wdat_r <= 32'd0;
            oor_r  <= 1'b0;
        end else if (accept_s) begin
            idx_r  <= adr_i[AW+1:2];
            we_r   <= we_i;
            sel_r  <= sel_i;
            wdat_r <= dat_i;
            oor_r  <= req_oor_s;
        end
    end

    // Byte-lane RAM write at the commit edge.
    always_ff @(posedge clk) begin
        if (commit_s && cur_we_s && !cur_oor_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_sel_s[i]) begin
                    mem_r[cur_idx_s][8*i +: 8] <= cur_dat_s[8*i +: 8];
                end
            end
        end
    end

    // Registered response; dat_o only moves on a read commit or an errored transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_o <= 1'b0;
            err_r <= 1'b0;
            dat_o <= 32'd0;
        end else begin
            ack_o <= (state_r == ST_RESP) && !oor_r;
            err_r <= (state_r == ST_RESP) && oor_r;
            if (commit_s && (cur_oor_s || !cur_we_s)) begin
                dat_o <= cur_oor_s ? 32'd0 : mem_r[cur_idx_s];
            end
        end
    end

`ifdef RAM_ERR_EN
    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

    logic unused_s;
    assign unused_s = &{1'b0, adr_i[1:0], adr_i[ADR_W-1:AW+2], err_r};

endmodule

// File: doc/wb_ram_responder.md
Name: wb_ram_responder

Overview:
- Wishbone B4 classic-cycle responder with 32-bit data.
- Word-organised RAM behind the bus, with byte-lane writes and a programmable number of wait states.
- Serves as the bus target for the core's load/store unit in unit benches and small SoC builds.
- Completes each transfer with ack, or with err when the optional feature is enabled.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- WAIT_STATES, 0: idle cycles inserted between request acceptance and ack; range 0..15.
- ADR_W, 32: width of the Wishbone byte address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe / transfer request.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADR_W  byte address; bits [1:0] ignored.
- sel_i  in  4  byte-lane select; bit i covers dat bits [8i+7:8i].
- dat_i  in  32  write data.
- dat_o  out  32  read data, registered.
- ack_o  out  1  transfer done, registered.
- err_o  out  1  transfer error, registered; only driven when RAM_ERR_EN is defined.

Behaviour:
- Reset (rst=0, async): state=IDLE, ack_o=0, err_o=0, dat_o=0. RAM contents are not reset.
- Word index = adr_i[log2(DEPTH)+1:2].
- States:
  - IDLE: on a clk edge with cyc_i&stb_i=1, capture adr/we/sel/dat into holding regs and load wait counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: counter decrements each edge. When counter==1, go to RESP. If cyc_i=0 on any edge, abort to IDLE: no write, no ack.
  - RESP: ack_o=1 (or err_o=1) for exactly one cycle, then IDLE unconditionally.
- Commit point is the edge that enters RESP:
  - Write: RAM[word] byte i <= captured dat byte i for every captured sel bit set. sel=0000 still acks and writes nothing.
  - Read: dat_o <= RAM[word], full 32 bits regardless of sel; the initiator performs extraction and sign-extension.
- dat_o holds its value until the next read commit. Writes do not alter dat_o.
- Latency: ack_o is high in the cycle starting WAIT_STATES+1 edges after the accepting edge.
- Throughput: one transfer per WAIT_STATES+2 cycles.
- ack_o is never high two consecutive cycles.
- stb_i held high through RESP is not re-accepted in RESP. It is accepted on the following edge in IDLE as a new transfer, which gives back-to-back operation.
- Inputs are not sampled in WAIT or RESP; changes there are ignored.
- Read-after-write to the same word, back-to-back, returns the newly written data.
- Reset asserted mid-transfer: immediate IDLE, outputs cleared, pending write discarded.

Optional Feature:
- Macro: RAM_ERR_EN.
- Defined:
  - A request with adr_i >= DEPTH*4 (any upper bit set) still passes through WAIT.
  - In RESP it asserts err_o=1 instead of ack_o. No RAM write occurs and dat_o is set to 0.
- Undefined:
  - Upper address bits are ignored, so addresses alias modulo DEPTH*4.
  - err_o is tied to 0.

Test Plan:
- Reset then word write/read, WAIT_STATES=0: write adr=0x10 dat=0xDEADBEEF sel=1111 -> ack 1 cycle after accept. Then read adr=0x10 -> dat_o=0xDEADBEEF, ack after 1 cycle, with dat_o=0 before the first read.
- Byte lanes: preload 0x11223344 at 0x20, write dat=0xAABBCCDD sel=0101 -> readback 0x11BB33DD. sel=0000 write acks and leaves the word unchanged.
- Wait states, WAIT_STATES=3: read accepted at edge N -> ack_o high only in the cycle after edge N+4. Back-to-back stb held -> acks spaced 5 cycles apart, never adjacent.
- Abort: WAIT_STATES=3, write 0xCAFEF00D to 0x40 with cyc_i dropped after 2 cycles -> no ack. Subsequent read of 0x40 returns the prior value. Repeat with rst pulsed low mid-WAIT -> outputs 0 asynchronously, write discarded.
- Out of range, DEPTH=1024:
  - With RAM_ERR_EN: write to 0x1000 -> err_o=1, ack_o=0, word 0 unchanged.
  - Without RAM_ERR_EN: write 0x12345678 to 0x1000 -> ack, and a read of 0x0 returns 0x12345678.
- Alignment: write adr=0x33 sel=1000 dat=0x7F000000 -> byte 3 of word 0x30 = 0x7F; adr[1:0] confirmed ignored.
